// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: 2-entry instruction buffer with branch pre-decode for fetch.
// Optional IF_ID_PERF_EN adds saturating stall/flush event counters.
module if_id_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] instr_i,
  input  logic             instr_valid_i,
  output logic             fetch_ready_o,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             id_valid_o,
  output logic [WIDTH-1:0] id_pc_o,
  output logic [WIDTH-1:0] id_instr_o,
  output logic [7:0]       cond_address_o,
  output logic [10:0]      uncond_address_o,
  output logic [5:0]       link_address_o,
  output logic [1:0]       branch_type_o,
  output logic             reg_branch_o,
  output logic             is_branch_o
`ifdef IF_ID_PERF_EN
  ,
  output logic [15:0]      stall_cnt_o,
  output logic [15:0]      flush_cnt_o
`endif
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [WIDTH-1:0] pc_mem    [2];
  logic [WIDTH-1:0] instr_mem [2];
  logic             push;
  logic             pop;

  // Ready depends only on registered count, so stall never reaches fetch combinationally.
  assign fetch_ready_o = (count < FULL);
  assign id_valid_o    = (count != 2'd0);
  assign push          = instr_valid_i && fetch_ready_o && !flush_i;
  assign pop           = id_valid_o && !stall_i && !flush_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush_i) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= pc_i;
        instr_mem[wr_ptr] <= instr_i;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign id_pc_o    = id_valid_o ? pc_mem[rd_ptr]    : '0;
  assign id_instr_o = id_valid_o ? instr_mem[rd_ptr] : '0;

  // id_instr_o is already zero when empty, so the decode needs no separate valid gate.
  always_comb begin
    cond_address_o   = id_instr_o[7:0];
    uncond_address_o = id_instr_o[10:0];
    link_address_o   = id_instr_o[5:0];
    branch_type_o    = 2'b00;
    reg_branch_o     = 1'b0;
    is_branch_o      = 1'b0;
    case (id_instr_o[15:12])
      4'hC: begin
        branch_type_o = 2'b00;
        is_branch_o   = 1'b1;
      end
      4'hD: begin
        branch_type_o = 2'b01;
        is_branch_o   = 1'b1;
      end
      4'hE: begin
        branch_type_o = 2'b10;
        is_branch_o   = 1'b1;
      end
      4'hF: begin
        branch_type_o = 2'b11;
        reg_branch_o  = 1'b1;
        is_branch_o   = 1'b1;
      end
      default: begin
        branch_type_o = 2'b00;
      end
    endcase
  end

`ifdef IF_ID_PERF_EN
  logic [16:0] stall_sum;
  logic [16:0] flush_sum;
  logic [2:0]  flush_drop;

  // A presented instruction is counted as discarded on flush even when the buffer was full.
  assign flush_drop = {1'b0, count} + {2'b00, instr_valid_i};
  assign stall_sum  = {1'b0, stall_cnt_o} + 17'd1;
  assign flush_sum  = {1'b0, flush_cnt_o} + {14'd0, flush_drop};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_o <= 16'd0;
      flush_cnt_o <= 16'd0;
    end else begin
      if (id_valid_o && stall_i && !flush_i) begin
        stall_cnt_o <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
      end
      if (flush_i) begin
        flush_cnt_o <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed vector bench for if_id_stage: table-driven buffer/decode checks plus
// async-reset and perf-counter sequences.
module tb_if_id_stage;

  logic        clk;
  logic        reset;
  logic [15:0] pc_i;
  logic [15:0] instr_i;
  logic        instr_valid_i;
  logic        fetch_ready_o;
  logic        stall_i;
  logic        flush_i;
  logic        id_valid_o;
  logic [15:0] id_pc_o;
  logic [15:0] id_instr_o;
  logic [7:0]  cond_address_o;
  logic [10:0] uncond_address_o;
  logic [5:0]  link_address_o;
  logic [1:0]  branch_type_o;
  logic        reg_branch_o;
  logic        is_branch_o;
`ifdef IF_ID_PERF_EN
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;
`endif

  int n_vec;
  int n_bad;

  if_id_stage #(.WIDTH(16), .DEPTH(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .pc_i             (pc_i),
    .instr_i          (instr_i),
    .instr_valid_i    (instr_valid_i),
    .fetch_ready_o    (fetch_ready_o),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .id_valid_o       (id_valid_o),
    .id_pc_o          (id_pc_o),
    .id_instr_o       (id_instr_o),
    .cond_address_o   (cond_address_o),
    .uncond_address_o (uncond_address_o),
    .link_address_o   (link_address_o),
    .branch_type_o    (branch_type_o),
    .reg_branch_o     (reg_branch_o),
    .is_branch_o      (is_branch_o)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic [15:0] in_pc;
    logic [15:0] in_instr;
    logic        in_stall;
    logic        in_flush;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic        e_ready;
    logic [7:0]  e_cond;
    logic [10:0] e_unc;
    logic [5:0]  e_link;
    logic [1:0]  e_bt;
    logic        e_regbr;
    logic        e_isbr;
  } vec_t;

  vec_t vec [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " valid"}, 32'(id_valid_o), 32'd0);
    check({tag, " pc"}, 32'(id_pc_o), 32'd0);
    check({tag, " instr"}, 32'(id_instr_o), 32'd0);
    check({tag, " ready"}, 32'(fetch_ready_o), 32'd1);
    check({tag, " isbr"}, 32'(is_branch_o), 32'd0);
    check({tag, " bt"}, 32'(branch_type_o), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    //            valid pc        instr      stl flu | v  pc        instr      rdy cond   unc      link   bt     rb isb
    vec[0]  = '{1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h1234, 1'b1, 8'h34, 11'h234, 6'h34, 2'b00, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 8'h00, 11'h000, 6'h00, 2'b00, 1'b0, 1'b0};
    vec[2]  = '{1'b1, 16'h0020, 16'hA020, 1'b1, 1'b0, 1'b1, 16'h0020, 16'hA020, 1'b1, 8'h20, 11'h020, 6'h20, 2'b00, 1'b0, 1'b0};
    vec[3]  = '{1'b1, 16'h0021, 16'hA021, 1'b1, 1'b0, 1'b1, 16'h0020, 16'hA020, 1'b0, 8'h20, 11'h020, 6'h20, 2'b00, 1'b0, 1'b0};
    vec[4]  = '{1'b1, 16'h0022, 16'hA022, 1'b1, 1'b0, 1'b1, 16'h0020, 16'hA020, 1'b0, 8'h20, 11'h020, 6'h20, 2'b00, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0021, 16'hA021, 1'b1, 8'h21, 11'h021, 6'h21, 2'b00, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 8'h00, 11'h000, 6'h00, 2'b00, 1'b0, 1'b0};
    vec[7]  = '{1'b1, 16'h0030, 16'hC3F5, 1'b0, 1'b0, 1'b1, 16'h0030, 16'hC3F5, 1'b1, 8'hF5, 11'h3F5, 6'h35, 2'b00, 1'b0, 1'b1};
    vec[8]  = '{1'b1, 16'h0031, 16'hF002, 1'b0, 1'b0, 1'b1, 16'h0031, 16'hF002, 1'b1, 8'h02, 11'h002, 6'h02, 2'b11, 1'b1, 1'b1};
    vec[9]  = '{1'b1, 16'h0032, 16'hD7FF, 1'b0, 1'b0, 1'b1, 16'h0032, 16'hD7FF, 1'b1, 8'hFF, 11'h7FF, 6'h3F, 2'b01, 1'b0, 1'b1};
    vec[10] = '{1'b1, 16'h0033, 16'hE041, 1'b1, 1'b0, 1'b1, 16'h0032, 16'hD7FF, 1'b0, 8'hFF, 11'h7FF, 6'h3F, 2'b01, 1'b0, 1'b1};
    vec[11] = '{1'b1, 16'h0034, 16'h1111, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 8'h00, 11'h000, 6'h00, 2'b00, 1'b0, 1'b0};
    vec[12] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 8'h00, 11'h000, 6'h00, 2'b00, 1'b0, 1'b0};
    vec[13] = '{1'b1, 16'h0040, 16'hE041, 1'b1, 1'b0, 1'b1, 16'h0040, 16'hE041, 1'b1, 8'h41, 11'h041, 6'h01, 2'b10, 1'b0, 1'b1};
    vec[14] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 8'h00, 11'h000, 6'h00, 2'b00, 1'b0, 1'b0};

    reset         = 1'b0;
    pc_i          = '0;
    instr_i       = '0;
    instr_valid_i = 1'b0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    #3;
    check_idle("reset");
`ifdef IF_ID_PERF_EN
    check("reset stall_cnt", 32'(stall_cnt_o), 32'd0);
    check("reset flush_cnt", 32'(flush_cnt_o), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      instr_valid_i = vec[i].in_valid;
      pc_i          = vec[i].in_pc;
      instr_i       = vec[i].in_instr;
      stall_i       = vec[i].in_stall;
      flush_i       = vec[i].in_flush;
      @(posedge clk);
      #1;
      check($sformatf("v%0d valid", i), 32'(id_valid_o), 32'(vec[i].e_valid));
      check($sformatf("v%0d pc", i), 32'(id_pc_o), 32'(vec[i].e_pc));
      check($sformatf("v%0d instr", i), 32'(id_instr_o), 32'(vec[i].e_instr));
      check($sformatf("v%0d ready", i), 32'(fetch_ready_o), 32'(vec[i].e_ready));
      check($sformatf("v%0d cond", i), 32'(cond_address_o), 32'(vec[i].e_cond));
      check($sformatf("v%0d uncond", i), 32'(uncond_address_o), 32'(vec[i].e_unc));
      check($sformatf("v%0d link", i), 32'(link_address_o), 32'(vec[i].e_link));
      check($sformatf("v%0d btype", i), 32'(branch_type_o), 32'(vec[i].e_bt));
      check($sformatf("v%0d regbr", i), 32'(reg_branch_o), 32'(vec[i].e_regbr));
      check($sformatf("v%0d isbr", i), 32'(is_branch_o), 32'(vec[i].e_isbr));
`ifdef IF_ID_PERF_EN
      if (i == 11) check("flush_cnt after full flush", 32'(flush_cnt_o), 32'd3);
`endif
    end
    instr_valid_i = 1'b0;
    flush_i       = 1'b0;
    stall_i       = 1'b0;

`ifdef IF_ID_PERF_EN
    check("stall_cnt total", 32'(stall_cnt_o), 32'd3);
    check("flush_cnt total", 32'(flush_cnt_o), 32'd4);
`endif

    // Load one entry, then pull reset between edges.
    instr_valid_i = 1'b1;
    pc_i          = 16'h0050;
    instr_i       = 16'hC0AA;
    @(posedge clk);
    #1;
    instr_valid_i = 1'b0;
    check("pre-reset valid", 32'(id_valid_o), 32'd1);
    check("pre-reset pc", 32'(id_pc_o), 32'h0050);
    #2;
    reset = 1'b0;
    #1;
    check_idle("async reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset valid", 32'(id_valid_o), 32'd0);
    instr_valid_i = 1'b1;
    pc_i          = 16'h0060;
    instr_i       = 16'h5678;
    @(posedge clk);
    #1;
    instr_valid_i = 1'b0;
    check("post-reset push valid", 32'(id_valid_o), 32'd1);
    check("post-reset push pc", 32'(id_pc_o), 32'h0060);
    check("post-reset push instr", 32'(id_instr_o), 32'h5678);
`ifdef IF_ID_PERF_EN
    check("post-reset stall_cnt", 32'(stall_cnt_o), 32'd0);
    check("post-reset flush_cnt", 32'(flush_cnt_o), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline stage between instruction fetch and decode.
- Captures each fetched instruction and its PC in a 2-entry buffer and presents the oldest entry to decode.
- Holds the entry while decode is stalled and drops all entries on a taken-branch flush.
- Pre-decodes the branch fields (cond/uncond/link offsets, branch_type, reg_branch) that the fetch stage's branch-target logic consumes.

Parameters:
- WIDTH, 16, instruction and PC width.
- DEPTH, 2, buffer entries; only the value 2 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc_i  input  WIDTH  PC of the fetched instruction.
- instr_i  input  WIDTH  fetched instruction.
- instr_valid_i  input  1  fetch presents a valid instruction this cycle.
- fetch_ready_o  output  1  stage can accept an instruction this cycle.
- stall_i  input  1  decode/hazard unit holds the ID stage.
- flush_i  input  1  branch taken (BrTaken); discard all buffered instructions.
- id_valid_o  output  1  head entry valid.
- id_pc_o  output  WIDTH  head entry PC.
- id_instr_o  output  WIDTH  head entry instruction.
- cond_address_o  output  8  instr[7:0] of head entry.
- uncond_address_o  output  11  instr[10:0] of head entry.
- link_address_o  output  6  instr[5:0] of head entry.
- branch_type_o  output  2  00 cond, 01 uncond, 10 link, 11 register.
- reg_branch_o  output  1  head entry is a register branch.
- is_branch_o  output  1  head entry opcode is in 4'hC..4'hF.

Behaviour:
- Reset (reset=0, asynchronous): count=0, rd/wr pointers=0, all storage=0.
  - All outputs 0, except fetch_ready_o=1 once count=0.
- Push: instr_valid_i && fetch_ready_o && !flush_i.
  - Writes {pc_i, instr_i} at wr_ptr on the clock edge; wr_ptr toggles.
- Pop: id_valid_o && !stall_i && !flush_i.
  - Advances rd_ptr; count decrements.
- fetch_ready_o = (count < 2). Combinational from registered count only; no combinational path from stall_i.
- id_valid_o = (count != 0). id_pc_o and id_instr_o come from the entry at rd_ptr and are 0 when count=0.
- Latency: an instruction pushed at edge N appears on the outputs after edge N when the buffer was empty. Otherwise it appears after the pop that exposes it.
- Push and pop in the same cycle at count=1: count stays 1 and the new entry becomes head next cycle.
- count=2: no push (ready=0). A pop makes ready=1 in the following cycle, not the same one.
- Flush:
  - Next edge: count=0 and pointers=0.
  - The same-cycle push is dropped and the same-cycle pop has no effect.
  - Flush has priority over stall.
- Stall with count=0: no effect; pushes proceed.
- Pointers wrap modulo 2.
- Pre-decode uses head instr[15:12]:
  - 4'hC: cond, branch_type=00.
  - 4'hD: uncond, branch_type=01.
  - 4'hE: link, branch_type=10.
  - 4'hF: register, branch_type=11, reg_branch_o=1.
  - Any other opcode: branch_type=00, reg_branch_o=0, is_branch_o=0.
- Offset fields (cond/uncond/link) are raw, not sign-extended; extension happens in fetch.
- When id_valid_o=0: all decoded outputs are 0.
- Reset asserted mid-operation: all state clears immediately, regardless of clk.

Optional Feature:
- Macro: IF_ID_PERF_EN.
- When defined, adds outputs stall_cnt_o [15:0] and flush_cnt_o [15:0].
  - stall_cnt_o increments every cycle with id_valid_o && stall_i && !flush_i.
  - flush_cnt_o increments by the number of entries discarded (count, plus 1 if a push was dropped) on each flush.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and counters do not exist and the remaining behaviour is identical.

Test Plan:
- Reset, then push pc=16'h0010, instr=16'h1234 with no stall.
  - Next cycle: id_valid_o=1, id_pc_o=16'h0010, id_instr_o=16'h1234, is_branch_o=0.
  - Following cycle (no further push): id_valid_o=0.
- Hold stall_i=1 and push 0x0020 then 0x0021.
  - count=2, fetch_ready_o=0, head stays 0x0020.
  - Release stall: 0x0020 then 0x0021 emerge in order, and ready returns to 1 one cycle after the first pop.
- Push instr=16'hC3F5.
  - Expect cond_address_o=8'hF5, branch_type_o=00, is_branch_o=1.
- Push instr=16'hF002.
  - Expect branch_type_o=11, reg_branch_o=1, link_address_o=6'h02.
- With count=2, assert flush_i together with stall_i and instr_valid_i.
  - Next cycle: id_valid_o=0, count=0, fetch_ready_o=1.
  - With IF_ID_PERF_EN: flush_cnt_o=3.
- Drive reset low asynchronously between clock edges while count=1.
  - Outputs drop to 0 immediately.
  - After release, the first push appears normally.
